apb_master_slave: RTL and testbench
===================================

Name: apb_master_slave

Overview:
- Self-contained APB subsystem: an APB master FSM converts a simple command interface (address, write data, write/read select) into APB3 SETUP/ACCESS transfers.
- The master targets an internal zero-wait APB slave register-file memory.
- Read data from completed read transfers is returned on apb_rdata.
- Used as a standalone APB protocol block and as the unit under test for APB master/slave verification.

Parameters:
- ADDR_WIDTH, 10, width of apb_addr and of the internal PADDR.
- DATA_WIDTH, 32, width of write/read data and of each memory word.
- MEM_DEPTH, 2**ADDR_WIDTH, number of slave memory words (word-addressed).
- WAIT_STATES, 0, number of cycles the slave holds PREADY low in ACCESS before asserting it (0..7).

Ports:
- apb_clk  input  1  single clock; all state updates on rising edge.
- apb_resetn  input  1  reset, synchronous, active-high (name kept per codebase convention; a 1 sampled at a rising edge resets).
- apb_wdata  input  DATA_WIDTH  write data for the command.
- apb_addr  input  ADDR_WIDTH  word address for the command.
- apb_wr_rd  input  1  1 = write, 0 = read; any non-1 value (incl. X) is treated as read.
- apb_rdata  output  DATA_WIDTH  data of the most recently completed read transfer.

Behaviour:
- Reset (apb_resetn=1 at a rising edge):
  - FSM goes to IDLE; internal PSEL/PENABLE/PWRITE = 0; PADDR/PWDATA = 0.
  - apb_rdata = 0; every memory word cleared to 0; wait counter = 0.
  - Reset has priority over everything, including a transfer in progress; that transfer is aborted and has no effect.
- FSM states and transitions:
  - IDLE: PSEL=0, PENABLE=0. On the next edge, capture apb_addr, apb_wdata and apb_wr_rd into PADDR/PWDATA/PWRITE, then go to SETUP. Commands are launched continuously; the master does not detect changes in the inputs.
  - SETUP: PSEL=1, PENABLE=0. Go to ACCESS unconditionally.
  - ACCESS: PSEL=1, PENABLE=1. If PREADY=1, complete the transfer and go to IDLE; otherwise stay in ACCESS.
- Inputs are sampled only in IDLE; changes during SETUP/ACCESS have no effect on the current transfer.
- Timing with WAIT_STATES=0:
  - Edge E0 (IDLE) captures the command; E1 enters ACCESS; E2 completes the transfer.
  - Transfer period = 3 cycles; a command held for 3 or more cycles is guaranteed to execute at least once.
  - Repeated execution of the same write or read is benign.
- Slave:
  - PREADY asserts after WAIT_STATES cycles in ACCESS, counted from ACCESS entry.
  - PSLVERR = 1 when PADDR >= MEM_DEPTH.
- Write completion (ACCESS && PREADY && PWRITE): mem[PADDR] <= PWDATA at that edge. The write is ignored on PSLVERR.
- Read completion (ACCESS && PREADY && !PWRITE):
  - apb_rdata <= mem[PADDR] at that edge.
  - On PSLVERR, apb_rdata <= 0.
  - apb_rdata holds its value between read completions and is unaffected by writes.
- Read latency: new data is visible on apb_rdata 3 + WAIT_STATES edges after the command is captured in IDLE.
- Read-after-write to the same address in consecutive transfers returns the newly written data (no bypass is needed; the writes are in separate transfers).
- Address wrap: none. The full ADDR_WIDTH range is valid when MEM_DEPTH = 2**ADDR_WIDTH.

Decomposition:
- Package apb_pkg: state enum {IDLE, SETUP, ACCESS}, default width constants, and the APB signal bundle typedef (psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr).
- Sub-module apb_slave_mem: APB slave with the memory array, wait-state counter, PREADY and PSLVERR.
- apb_master_slave contains the master FSM, apb_rdata register, and the slave instance.

Test Plan:
- Reset: hold apb_resetn=1 for 2 cycles with apb_wr_rd=X -> apb_rdata=0; PSEL=0; no memory write.
- Write burst then read: write 0xDEADBEEF, 0x12345678, 0xA5A5A5A5, 0x0, 0xFFFFFFFF to addresses 0..4, holding each 4 cycles. Then read 0..4 -> apb_rdata returns the same values in order, each 3 cycles after capture.
- Interleaved write-then-read per address 0..4 (each held 4 cycles) -> each read returns the value just written.
- Read without prior write: after reset, read address 5 -> apb_rdata=0.
- Wait states: WAIT_STATES=2, write 0xCAFEF00D to address 1023 then read it -> ACCESS lasts 3 cycles; apb_rdata=0xCAFEF00D 5 edges after capture.
- Reset mid-transfer: assert reset during ACCESS of a write of 0x11111111 to address 2 -> mem[2] stays 0; a later read of address 2 returns 0; FSM is in IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default sizes for the APB master/slave subsystem.
// The bus bundle documents the internal master-to-slave signal set at default widths.
package apb_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int MAX_WAIT_STATES    = 7;
  localparam int WAIT_CNT_WIDTH     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [DEFAULT_ADDR_WIDTH-1:0] paddr;
    logic [DEFAULT_DATA_WIDTH-1:0] pwdata;
    logic [DEFAULT_DATA_WIDTH-1:0] prdata;
    logic                          pready;
    logic                          pslverr;
  } apb_bus_t;

endpackage

// File: rtl/apb_slave_mem.sv
// Zero-or-fixed-wait APB slave backed by a word-addressed register-file memory.
// PREADY rises after WAIT_STATES cycles of ACCESS; out-of-range addresses raise PSLVERR.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int MEM_DEPTH   = 2**ADDR_WIDTH,
  parameter int WAIT_STATES = 0
) (
  input  logic                  apb_clk,
  input  logic                  apb_resetn,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  output logic [DATA_WIDTH-1:0] o_prdata,
  output logic                  o_pready,
  output logic                  o_pslverr
);

  localparam logic [ADDR_WIDTH:0]       DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_TARGET = WAIT_CNT_WIDTH'(WAIT_STATES);

  logic [WAIT_CNT_WIDTH-1:0] r_waitCnt;
  logic [DATA_WIDTH-1:0]     r_mem [MEM_DEPTH];
  logic                      w_access;
  logic                      w_pready;
  logic                      w_pslverr;

  assign w_access  = i_psel && i_penable;
  assign w_pready  = w_access && (r_waitCnt == WAIT_TARGET);
  assign w_pslverr = i_psel && ({1'b0, i_paddr} >= DEPTH_LIMIT);

  assign o_pready  = w_pready;
  assign o_pslverr = w_pslverr;
  assign o_prdata  = w_pslverr ? '0 : r_mem[i_paddr];

  // Counter sits at zero outside ACCESS so every transfer sees the full wait.
  always_ff @(posedge apb_clk) begin
    if (apb_resetn) begin
      r_waitCnt <= '0;
    end else if (w_access && !w_pready) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end else begin
      r_waitCnt <= '0;
    end
  end

  always_ff @(posedge apb_clk) begin
    if (apb_resetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_pready && i_pwrite && !w_pslverr) begin
      r_mem[i_paddr] <= i_pwdata;
    end
  end

endmodule

// File: rtl/apb_master_slave.sv
// APB3 master FSM that relaunches the presented command every transfer period,
// wired to an internal memory slave; completed reads land on apb_rdata.
module apb_master_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int MEM_DEPTH   = 2**ADDR_WIDTH,
  parameter int WAIT_STATES = 0
) (
  input  logic                  apb_clk,
  input  logic                  apb_resetn,
  input  logic [DATA_WIDTH-1:0] apb_wdata,
  input  logic [ADDR_WIDTH-1:0] apb_addr,
  input  logic                  apb_wr_rd,
  output logic [DATA_WIDTH-1:0] apb_rdata
);

  apb_state_e            r_state;
  apb_state_e            w_nextState;
  logic                  w_psel;
  logic                  w_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_pready;
  logic                  w_pslverr;

  assign w_psel    = (r_state != IDLE);
  assign w_penable = (r_state == ACCESS);
  assign apb_rdata = r_rdata;

  always_ff @(posedge apb_clk) begin
    if (apb_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    w_nextState = SETUP;
      SETUP:   w_nextState = ACCESS;
      ACCESS:  w_nextState = w_pready ? IDLE : ACCESS;
      default: w_nextState = IDLE;
    endcase
  end

  // Only an explicit 1 selects a write; X or 0 on the select falls back to a read.
  always_ff @(posedge apb_clk) begin
    if (apb_resetn) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else if (r_state == IDLE) begin
      r_paddr  <= apb_addr;
      r_pwdata <= apb_wdata;
      r_pwrite <= (apb_wr_rd === 1'b1);
    end
  end

  always_ff @(posedge apb_clk) begin
    if (apb_resetn) begin
      r_rdata <= '0;
    end else if (w_penable && w_pready && !r_pwrite) begin
      r_rdata <= w_pslverr ? '0 : w_prdata;
    end
  end

  apb_slave_mem #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .MEM_DEPTH   (MEM_DEPTH),
    .WAIT_STATES (WAIT_STATES)
  ) u_slave (
    .apb_clk    (apb_clk),
    .apb_resetn (apb_resetn),
    .i_psel     (w_psel),
    .i_penable  (w_penable),
    .i_pwrite   (r_pwrite),
    .i_paddr    (r_paddr),
    .i_pwdata   (r_pwdata),
    .o_prdata   (w_prdata),
    .o_pready   (w_pready),
    .o_pslverr  (w_pslverr)
  );

endmodule

// File: tb/tb_apb_master_slave.sv
// Self-checking bench: a zero-wait and a two-wait instance driven by command-level
// scenarios and random traffic, checked against a plain memory model.
module tb_apb_master_slave;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
  logic [AW-1:0] addr0, addr1;
  logic          wrRd0, wrRd1;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] modelMem [2][1024];
  logic [DW-1:0] expRd [2];

  always #5 clk = ~clk;

  apb_master_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) dut0 (
    .apb_clk(clk), .apb_resetn(rst), .apb_wdata(wdata0),
    .apb_addr(addr0), .apb_wr_rd(wrRd0), .apb_rdata(rdata0)
  );

  apb_master_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(2)) dut1 (
    .apb_clk(clk), .apb_resetn(rst), .apb_wdata(wdata1),
    .apb_addr(addr1), .apb_wr_rd(wrRd1), .apb_rdata(rdata1)
  );

  function automatic logic obsPsel(int u);
    return (u == 0) ? dut0.w_psel : dut1.w_psel;
  endfunction

  function automatic logic obsPenable(int u);
    return (u == 0) ? dut0.w_penable : dut1.w_penable;
  endfunction

  function automatic logic [DW-1:0] obsRdata(int u);
    return (u == 0) ? rdata0 : rdata1;
  endfunction

  task automatic clearModel();
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < 1024; a++) modelMem[u][a] = '0;
      expRd[u] = '0;
    end
  endtask

  task automatic setCmd(int u, logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    if (u == 0) begin
      wrRd0 = wr; addr0 = a; wdata0 = d;
    end else begin
      wrRd1 = wr; addr1 = a; wdata1 = d;
    end
  endtask

  // Launch one command on a capture edge, then check latency, ACCESS length and read data.
  task automatic doCmd(int u, logic wr, logic [AW-1:0] a, logic [DW-1:0] d, string tag);
    int            ws;
    int            guard;
    int            accessCycles;
    logic [DW-1:0] expNew;
    ws = (u == 0) ? 0 : 2;
    guard = 0;
    accessCycles = 0;
    while (obsPsel(u) !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (obsPsel(u) !== 1'b0) begin
      checks++; failures++;
      $display("[TB] FAIL %s idle_timeout u=%0d psel=%b required 0", tag, u, obsPsel(u));
      return;
    end
    setCmd(u, wr, a, d);
    expNew = wr ? expRd[u] : modelMem[u][a];
    for (int k = 1; k <= 3 + ws; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (obsPenable(u) === 1'b1) accessCycles++;
      if (k == 2 + ws) begin
        checks++;
        if (obsRdata(u) !== expRd[u]) begin
          failures++;
          $display("[TB] FAIL %s early_rdata u=%0d addr=%0d got=%h required=%h",
                   tag, u, a, obsRdata(u), expRd[u]);
        end
      end
    end
    checks++;
    if (obsRdata(u) !== expNew) begin
      failures++;
      $display("[TB] FAIL %s rdata u=%0d wr=%b addr=%0d got=%h required=%h",
               tag, u, wr, a, obsRdata(u), expNew);
    end
    checks++;
    if (accessCycles != ws + 1) begin
      failures++;
      $display("[TB] FAIL %s access_len u=%0d got=%0d required=%0d",
               tag, u, accessCycles, ws + 1);
    end
    if (wr) modelMem[u][a] = d;
    expRd[u] = expNew;
  endtask

  task automatic doReset();
    rst = 1'b1;
    setCmd(0, 1'b0, '0, '0);
    setCmd(1, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
  endtask

  task automatic test_reset();
    logic [AW-1:0] ra;
    ra = AW'($urandom_range(0, 1023));
    rst = 1'b1;
    wrRd0 = 1'bx; wrRd1 = 1'bx;
    addr0 = ra; addr1 = ra;
    wdata0 = $urandom; wdata1 = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (obsRdata(u) !== '0) begin
        failures++;
        $display("[TB] FAIL reset_rdata u=%0d got=%h required=0", u, obsRdata(u));
      end
      checks++;
      if (obsPsel(u) !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_psel u=%0d got=%b required=0", u, obsPsel(u));
      end
    end
    setCmd(0, 1'b0, '0, '0);
    setCmd(1, 1'b0, '0, '0);
    rst = 1'b0;
    clearModel();
    doCmd(0, 1'b0, ra, '0, "reset_no_write0");
    doCmd(1, 1'b0, ra, '0, "reset_no_write1");
  endtask

  task automatic test_write_burst_read();
    logic [DW-1:0] vals [5];
    vals = '{32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) doCmd(0, 1'b1, AW'(i), vals[i], "burst_write");
    for (int i = 0; i < 5; i++) doCmd(0, 1'b0, AW'(i), '0, "burst_read");
  endtask

  task automatic test_interleaved();
    for (int i = 0; i < 5; i++) begin
      doCmd(0, 1'b1, AW'(i), $urandom, "inter_write");
      doCmd(0, 1'b0, AW'(i), '0, "inter_read");
    end
  endtask

  task automatic test_read_unwritten();
    doReset();
    doCmd(0, 1'b0, AW'(5), '0, "unwritten_addr5");
    doCmd(0, 1'b0, AW'(0), '0, "cleared_addr0");
  endtask

  task automatic test_wait_states();
    doCmd(1, 1'b1, AW'(1023), 32'hCAFEF00D, "ws_write");
    doCmd(1, 1'b0, AW'(1023), '0, "ws_read");
  endtask

  task automatic test_random();
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 30; n++) begin
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 1023))
                                        : AW'($urandom_range(0, 7));
        doCmd(u, logic'($urandom_range(0, 1)), a, $urandom, "random");
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    int guard;
    guard = 0;
    doCmd(1, 1'b1, AW'(3), 32'h5A5A0003, "pre_abort_write");
    while (obsPsel(1) !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    setCmd(1, 1'b1, AW'(2), 32'h11111111);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obsPenable(1) !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_in_access penable=%b required 1", obsPenable(1));
    end
    rst = 1'b1;
    setCmd(0, 1'b0, AW'(2), '0);
    setCmd(1, 1'b0, AW'(2), '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
    checks++;
    if (obsPsel(1) !== 1'b0 || obsPenable(1) !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_idle psel=%b penable=%b required 0 0",
               obsPsel(1), obsPenable(1));
    end
    doCmd(1, 1'b0, AW'(2), '0, "abort_addr2");
    doCmd(1, 1'b0, AW'(3), '0, "abort_cleared_addr3");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    clearModel();
    test_reset();
    test_write_burst_read();
    test_interleaved();
    test_read_unwritten();
    test_wait_states();
    test_random();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
